fixed_point_sqrt_iter: RTL
==========================

// Module: fixed_point_sqrt_iter
// PURPOSE
//  Iterative, parametrised unsigned fixed-point square root for the arithmetic datapath.
//  Computes Result = floor(sqrt(Operand)) in the same Q(WIDTH-SCALE).SCALE format as Operand.
//  Covers the full operand range; no range limit and no approximation.
//  Restoring digit-by-digit algorithm, one root bit per clock; valid/busy handshake.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SCALE  17  fractional bits of operand and result
//  Derived (localparam, not overridable):
//   RW = WIDTH+SCALE rounded up to even  radicand width
//   NITER = RW/2                          iterations
//   CW = clog2(NITER+1)                   counter width
//  Legal only if NITER <= WIDTH; elaboration error ($error) otherwise.
// PORTS
//  Clock        in   1      rising-edge clock
//  Reset        in   1      synchronous, active-high reset
//  Operand      in   WIDTH  unsigned fixed-point radicand, sampled on accept
//  iInputReady  in   1      request; accepted only when oBusy==0
//  oBusy        out  1      1 while a computation is in flight
//  OutputReady  out  1      one-cycle pulse: Result valid
//  Result       out  WIDTH  root, held stable until the next OutputReady
// BEHAVIOUR
//  Reset (sync): state=IDLE, oBusy=0, OutputReady=0, Result=0; internal regs cleared.
//  Reset asserted mid-operation aborts the computation; no OutputReady pulse is produced.
//  Radicand N = {pad, Operand, SCALE zeros}, RW bits, zero-extended at the MSB.
//  Root satisfies R^2 <= N < (R+1)^2.
//  States:
//   IDLE: oBusy=0. On iInputReady=1, latch N, clear rem/root, cnt=NITER-1, go to CALC.
//   CALC: oBusy=1. Per cycle:
//    rem' = {rem, N[2 top bits]}; N <<= 2; trial = {root, 2'b01}.
//    If rem' >= trial: rem = rem'-trial and root = {root,1}; else rem = rem' and root = {root,0}.
//    cnt==0 -> ROUND (or DONE if the macro is off); otherwise cnt--.
//   DONE: OutputReady=1 for exactly this cycle; Result register loaded with the root.
//    oBusy=0 in DONE.
//    iInputReady=1 here is accepted (back-to-back): go to CALC; otherwise go to IDLE.
//  Latency: accept edge at cycle T -> OutputReady high during cycle T+NITER+1 (macro off).
//  Throughput: one result per NITER+1 cycles.
//  iInputReady while oBusy=1: ignored, no queueing, in-flight result unaffected.
//  Operand may change after the accept edge without effect.
//  Operand 0 -> Result 0. Result upper WIDTH-NITER bits are always 0.
//  rem width NITER+2 bits; no arithmetic overflow possible.
// CONFIGURATION
//  FIXED_SQRT_ROUND_EN defined:
//   Extra ROUND state (oBusy=1, 1 cycle) between CALC and DONE.
//   If rem > root, root++ (round to nearest; a tie is impossible).
//   Saturates at all-ones if NITER==WIDTH.
//   Latency NITER+2; throughput 1 per NITER+2.
//  FIXED_SQRT_ROUND_EN undefined:
//   No ROUND state; result truncated (floor); latency NITER+1.
// TESTING (WIDTH=32, SCALE=17: NITER=25, latency 26, 27 with ROUND)
//  1 Operand=0x00080000 (4.0) -> Result=0x00040000 (2.0), OutputReady at T+26, one cycle wide.
//  2 Operand=0x00040000 (2.0) -> Result=0x0002D413; with FIXED_SQRT_ROUND_EN -> 0x0002D414 at T+27.
//  3 Operand=0xFFFFFFFF -> Result=0x016A09E6; with FIXED_SQRT_ROUND_EN -> 0x016A09E7.
//    Operand=0 -> Result=0.
//  4 Pulse iInputReady at T+5 with a different Operand:
//    ignored, oBusy stays 1, result of the first operand unchanged.
//    Request held high in DONE -> second result exactly 26 cycles later.
//  5 Reset at T+10 -> next cycle oBusy=0, OutputReady=0, Result=0, no pulse at T+26.
//    A fresh request then completes normally.
//  6 Random sweep of 10k operands vs reference model floor/round(sqrt(Op*2^17)); zero mismatches.

Source files
------------

// File: rtl/fixed_point_sqrt_iter_if.sv
// Operand/result bus with request and busy/valid handshake for the iterative square root.
// Latency: none; this file only groups the signals.
// Backpressure: a request is taken only while oBusy is low, and no request is ever queued.
interface fixed_point_sqrt_iter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] Operand;
  logic             iInputReady;
  logic             oBusy;
  logic             OutputReady;
  logic [WIDTH-1:0] Result;

  modport master (
    output Operand,
    output iInputReady,
    input  oBusy,
    input  OutputReady,
    input  Result
  );

  modport slave (
    input  Operand,
    input  iInputReady,
    output oBusy,
    output OutputReady,
    output Result
  );
endinterface

// File: rtl/fixed_point_sqrt_iter.sv
// Unsigned fixed-point square root using the restoring method, one root bit per clock.
// Latency: NITER+1 cycles from accept to OutputReady, or NITER+2 when FIXED_SQRT_ROUND_EN is defined.
// Backpressure: requests are ignored while busy; a request held high during DONE starts the next operation.
// FIXED_SQRT_ROUND_EN: adds a ROUND state that rounds to nearest instead of truncating.
module fixed_point_sqrt_iter #(
  parameter int WIDTH = 32,
  parameter int SCALE = 17
) (
  input logic                    Clock,
  input logic                    Reset,
  fixed_point_sqrt_iter_if.slave bus
);

  localparam int RW    = ((WIDTH + SCALE + 1) / 2) * 2;
  localparam int NITER = RW / 2;
  localparam int CW    = $clog2(NITER + 1);

  if (NITER > WIDTH) begin : g_bad_width
    $error("fixed_point_sqrt_iter: NITER (%0d) exceeds WIDTH (%0d)", NITER, WIDTH);
  end
  if (NITER < 2) begin : g_bad_small
    $error("fixed_point_sqrt_iter: WIDTH+SCALE too small (NITER=%0d)", NITER);
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [RW-1:0]      rad;
  logic [NITER+1:0]   rem;
  logic [NITER-1:0]   root;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   result_q;

  logic               busy;
  logic               out_rdy;
  logic               accept;

  logic [NITER+3:0]   rem_shift;
  logic [NITER+3:0]   trial;
  logic               take;
  logic [NITER+1:0]   rem_step;
  logic [NITER-1:0]   root_step;

`ifdef FIXED_SQRT_ROUND_EN
  logic               round_up;
  logic [WIDTH-1:0]   root_res;
  logic [WIDTH:0]     root_inc;
  logic [WIDTH-1:0]   root_rnd;
`endif

  // State register; a synchronous reset aborts any operation in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs. DONE accepts a new request so that operations can run back to back.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_rdy    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iInputReady) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) begin
`ifdef FIXED_SQRT_ROUND_EN
          state_next = ROUND;
`else
          state_next = DONE;
`endif
        end
      end
      ROUND: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_rdy = 1'b1;
        if (bus.iInputReady) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: bring down the next two radicand bits and subtract the trial value 4*root+1 when it fits.
  // The compare is done at full width, and the remainder is kept at NITER+2 bits because it never exceeds 2*root.
  always_comb begin
    rem_shift = {rem, rad[RW-1 -: 2]};
    trial     = {2'b00, root, 2'b01};
    take      = (rem_shift >= trial);
    rem_step  = take ? (NITER+2)'(rem_shift - trial) : (NITER+2)'(rem_shift);
    root_step = {root[NITER-2:0], take};
  end

`ifdef FIXED_SQRT_ROUND_EN
  // Round to nearest. sqrt(N) >= R+0.5 exactly when N-R^2 > R, so a tie cannot occur.
  always_comb begin
    round_up = (rem > {2'b00, root});
    root_res = WIDTH'(root);
    root_inc = {1'b0, root_res} + {{WIDTH{1'b0}}, 1'b1};
    root_rnd = root_res;
    if (round_up) begin
      root_rnd = root_inc[WIDTH] ? {WIDTH{1'b1}} : root_inc[WIDTH-1:0];
    end
  end
`endif

  // Datapath registers: latch the radicand on accept, iterate in CALC,
  // and load Result on the edge that enters DONE so it is valid alongside OutputReady.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rad  <= RW'(bus.Operand) << SCALE;
        rem  <= '0;
        root <= '0;
        cnt  <= CW'(NITER - 1);
      end else if (state == CALC) begin
        rad  <= rad << 2;
        rem  <= rem_step;
        root <= root_step;
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
      end
`ifdef FIXED_SQRT_ROUND_EN
      if (state == ROUND) begin
        result_q <= root_rnd;
      end
`else
      if (state == CALC && cnt == '0) begin
        result_q <= WIDTH'(root_step);
      end
`endif
    end
  end

  assign bus.oBusy       = busy;
  assign bus.OutputReady = out_rdy;
  assign bus.Result      = result_q;

endmodule
